// File: rtl/inv_sub_bytes_seq.sv
// inv_sub_bytes_seq: iterative InvShiftRows + InvSubBytes stage for the
// AES-256 decryption round datapath. SBOX_LANES bytes are substituted per
// cycle, so a full 128-bit state takes N_ITER = 16/SBOX_LANES busy cycles.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. in_ready is high only in IDLE; out_valid is high only in
// DONE and stays high, with out_state stable, until out_ready is seen.
//
// Build option: define INV_SHIFT_ROWS_EN to apply InvShiftRows when the
// state is captured. Without it the capture is a straight copy and the block
// is pure byte-wise InvSubBytes. Latency and handshake are the same.
module inv_sub_bytes_seq #(
    parameter int SBOX_LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);
    localparam int N_ITER = 16 / SBOX_LANES;
    localparam int CW = (N_ITER > 1) ? $clog2(N_ITER) : 1;
    localparam logic [CW-1:0] LAST = CW'(N_ITER - 1);

    // Only lane counts that split 16 bytes into equal power-of-two groups.
    generate
        if (!(SBOX_LANES == 1 || SBOX_LANES == 2 || SBOX_LANES == 4 ||
              SBOX_LANES == 8 || SBOX_LANES == 16)) begin : g_bad_lanes
            $error("inv_sub_bytes_seq: SBOX_LANES=%0d is not 1, 2, 4, 8 or 16", SBOX_LANES);
        end
    endgenerate

    // FIPS-197 inverse S-box, indexed by the input byte.
    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [7:0]    work     [16];
    logic [7:0]    in_b     [16];
    logic [7:0]    cap      [16];
    logic [7:0]    work_nxt [16];
    logic [127:0]  work_nxt_flat;

`ifdef INV_SHIFT_ROWS_EN
    // Byte 4c+r of the result comes from row r, column (c-r) mod 4.
    function automatic logic [3:0] isr_src(input int k);
        int r;
        int c;
        r = k % 4;
        c = k / 4;
        return 4'(4 * ((c - r + 4) % 4) + r);
    endfunction
`endif

    // Unpack the input and form the captured working bytes.
    always_comb begin
        for (int k = 0; k < 16; k++) begin
            in_b[k] = in_state[127 - 8*k -: 8];
        end
        for (int k = 0; k < 16; k++) begin
`ifdef INV_SHIFT_ROWS_EN
            cap[k] = in_b[isr_src(k)];
`else
            cap[k] = in_b[k];
`endif
        end
    end

    // Substitute the current group of SBOX_LANES bytes in place.
    always_comb begin
        logic [3:0] idx;
        idx = '0;
        for (int k = 0; k < 16; k++) begin
            work_nxt[k] = work[k];
        end
        for (int l = 0; l < SBOX_LANES; l++) begin
            idx = 4'(int'(cnt) * SBOX_LANES + l);
            work_nxt[idx] = INV_SBOX[work[idx]];
        end
        for (int k = 0; k < 16; k++) begin
            work_nxt_flat[127 - 8*k -: 8] = work_nxt[k];
        end
    end

    // Control FSM with registered handshake outputs and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_state <= '0;
            for (int k = 0; k < 16; k++) begin
                work[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work     <= cap;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    work <= work_nxt;
                    if (cnt == LAST) begin
                        cnt       <= '0;
                        out_state <= work_nxt_flat;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Bench for inv_sub_bytes_seq: one instance per legal lane count (4 is the
// main instance), a GF(2^8)-derived inverse S-box reference, and an expected
// queue of result states. Honours the INV_SHIFT_ROWS_EN build option.
module tb_inv_sub_bytes_seq;
    localparam int NDUT = 5;

    function automatic int lanes_of(input int g);
        case (g)
            0:       return 4;
            1:       return 1;
            2:       return 2;
            3:       return 8;
            default: return 16;
        endcase
    endfunction

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid  [NDUT];
    logic         in_ready  [NDUT];
    logic [127:0] in_state  [NDUT];
    logic         out_valid [NDUT];
    logic         out_ready [NDUT];
    logic [127:0] out_state [NDUT];
    logic         busy      [NDUT];

    int           checks = 0;
    int           errors = 0;
    logic [7:0]   isb [256];
    logic [127:0] exp_q [$];

    localparam logic [127:0] VEC0F = 128'h000102030405060708090a0b0c0d0e0f;
`ifdef INV_SHIFT_ROWS_EN
    localparam logic [127:0] EXP0F = 128'h52f3a338_3009d79e_bf366afb_8140a5d5;
`else
    localparam logic [127:0] EXP0F = 128'h52096ad5_3036a538_bf40a39e_81f3d7fb;
`endif

    // Clock
    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        inv_sub_bytes_seq #(.SBOX_LANES(lanes_of(g))) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_state  (in_state[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_state (out_state[g]),
            .busy      (busy[g])
        );
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // Inverse S-box = field inverse of the inverse affine transform.
    task automatic build_isb();
        logic [7:0] x;
        logic [7:0] inv;
        for (int y = 0; y < 256; y++) begin
            x = rotl(8'(y), 1) ^ rotl(8'(y), 3) ^ rotl(8'(y), 6) ^ 8'h05;
            inv = 8'h00;
            if (x != 8'h00) begin
                for (int b = 1; b < 256; b++) begin
                    if (gmul(x, 8'(b)) == 8'h01) inv = 8'(b);
                end
            end
            isb[y] = inv;
        end
    endtask

    function automatic logic [127:0] ref_model(input logic [127:0] s);
        logic [7:0]   m [4][4];
        logic [127:0] o;
        int           sc;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                m[r][c] = s[127 - 8*(4*c + r) -: 8];
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
`ifdef INV_SHIFT_ROWS_EN
                sc = (c - r + 4) % 4;
`else
                sc = c;
`endif
                o[127 - 8*(4*c + r) -: 8] = isb[m[r][sc]];
            end
        end
        return o;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Entered and left at a negedge. Sends one state to DUT d, measures the
    // latency, holds out_ready low for 'hold' cycles, then takes the result.
    task automatic run_txn(input int d, input logic [127:0] data,
                           input logic [127:0] exp, input int hold);
        int           lat;
        int           n;
        int           w;
        logic [127:0] e;
        n = 16 / lanes_of(d);
        w = 0;
        while (in_ready[d] !== 1'b1 && w < 50) begin
            @(posedge clk); @(negedge clk); w++;
        end
        check("in_ready_idle", 128'(in_ready[d]), 128'd1);
        in_valid[d] = 1'b1;
        in_state[d] = data;
        exp_q.push_back(exp);
        @(posedge clk); @(negedge clk);
        in_valid[d] = 1'b0;
        in_state[d] = {$urandom, $urandom, $urandom, $urandom};
        lat = 0;
        while (out_valid[d] !== 1'b1 && lat < 40) begin
            check("in_ready_busy", 128'(in_ready[d]), 128'd0);
            check("busy_high", 128'(busy[d]), 128'd1);
            @(posedge clk); @(negedge clk); lat++;
        end
        check("latency", 128'(lat), 128'(n));
        e = exp_q.pop_front();
        check("out_state", out_state[d], e);
        check("in_ready_done", 128'(in_ready[d]), 128'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); @(negedge clk);
            check("hold_valid", 128'(out_valid[d]), 128'd1);
            check("hold_state", out_state[d], e);
            check("hold_in_ready", 128'(in_ready[d]), 128'd0);
        end
        out_ready[d] = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready[d] = 1'b0;
        check("out_valid_clear", 128'(out_valid[d]), 128'd0);
        check("in_ready_return", 128'(in_ready[d]), 128'd1);
        check("busy_low", 128'(busy[d]), 128'd0);
        check("state_after", out_state[d], e);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [127:0] r;
        logic         seen;
        build_isb();
        rst = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
            in_valid[d]  = 1'b0;
            in_state[d]  = '0;
            out_ready[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            check("rst_in_ready", 128'(in_ready[d]), 128'd1);
            check("rst_out_valid", 128'(out_valid[d]), 128'd0);
            check("rst_busy", 128'(busy[d]), 128'd0);
            check("rst_out_state", out_state[d], 128'd0);
        end

        // Directed vectors on the default instance.
        run_txn(0, '0, {16{8'h52}}, 0);
        run_txn(0, {16{8'h63}}, '0, 0);
        run_txn(0, {16{8'hff}}, {16{8'h7d}}, 0);
        run_txn(0, VEC0F, EXP0F, 2);

        // Backpressure for 10 cycles.
        r = {$urandom, $urandom, $urandom, $urandom};
        run_txn(0, r, ref_model(r), 10);

        // Random states with random backpressure.
        for (int i = 0; i < 12; i++) begin
            r = {$urandom, $urandom, $urandom, $urandom};
            run_txn(0, r, ref_model(r), $urandom_range(0, 3));
        end

        // Reset two cycles after an accept discards the in-flight state.
        in_valid[0] = 1'b1;
        in_state[0] = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); @(negedge clk);
        in_valid[0] = 1'b0;
        @(posedge clk); @(negedge clk);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        check("mid_rst_out_valid", 128'(out_valid[0]), 128'd0);
        check("mid_rst_in_ready", 128'(in_ready[0]), 128'd1);
        check("mid_rst_busy", 128'(busy[0]), 128'd0);
        check("mid_rst_out_state", out_state[0], 128'd0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); @(negedge clk);
            if (out_valid[0] !== 1'b0) seen = 1'b1;
        end
        check("no_stale_output", 128'(seen), 128'd0);
        run_txn(0, VEC0F, EXP0F, 0);

        // Lane-count sweep: same result, latency 16/SBOX_LANES.
        for (int d = 1; d < NDUT; d++) begin
            run_txn(d, VEC0F, EXP0F, 0);
            for (int i = 0; i < 2; i++) begin
                r = {$urandom, $urandom, $urandom, $urandom};
                run_txn(d, r, ref_model(r), $urandom_range(0, 2));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
